// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: register addresses decoded by the bus select
// logic and the OAM DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    HALT  = ST_HALT,
    ALIGN = ST_ALIGN,
    READ  = ST_READ,
    WRITE = ST_WRITE
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-bus view of the OAM DMA engine.
// Bus protocol: there is no valid/ready pair. The CPU requests a transfer by
// a single-cycle write (CPU_RW_n=0) of the page number to the DMA register;
// the engine answers with CPU_HALT, and while DMA_ACTIVE is high the bus
// address/direction/data come from DMA_ADDR/DMA_RW_n/DMA_DATA_OUT.
// BUS_DATA_IN is the read value for the address driven in the same cycle.
interface oam_dma_if;
  logic [15:0] CPU_ADDR;
  logic [7:0]  CPU_DATA_OUT;
  logic        CPU_RW_n;
  logic [7:0]  BUS_DATA_IN;
  logic        CPU_HALT;
  logic        DMA_ACTIVE;
  logic [15:0] DMA_ADDR;
  logic        DMA_RW_n;
  logic [7:0]  DMA_DATA_OUT;

  modport master (
    input  CPU_ADDR, CPU_DATA_OUT, CPU_RW_n, BUS_DATA_IN,
    output CPU_HALT, DMA_ACTIVE, DMA_ADDR, DMA_RW_n, DMA_DATA_OUT
  );

  modport slave (
    output CPU_ADDR, CPU_DATA_OUT, CPU_RW_n, BUS_DATA_IN,
    input  CPU_HALT, DMA_ACTIVE, DMA_ADDR, DMA_RW_n, DMA_DATA_OUT
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: a CPU write of page P to the DMA register halts the
// CPU and copies $PP00-$PPFF into OAMDATA, one read/write pair per byte.
// Optional debug outputs (index, done pulse) are built when OAM_DMA_DEBUG_EN
// is defined.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = nes_bus_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = nes_bus_pkg::OAMDATA_ADDR,
  parameter int          NUM_BYTES    = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  oam_dma_if.master   bus
`ifdef OAM_DMA_DEBUG_EN
  ,
  output logic [7:0]  DMA_INDEX_debug,
  output logic        DMA_DONE_debug
`endif
);
  import nes_bus_pkg::*;

  localparam logic [7:0] LAST_INDEX = 8'(NUM_BYTES - 1);

  oam_dma_state_t state_q, state_d;
  logic           parity_q, parity_d;
  logic [7:0]     page_q, page_d;
  logic [7:0]     index_q, index_d;
  logic [7:0]     latch_q, latch_d;

  logic           cpu_halt_q, cpu_halt_d;
  logic           dma_active_q, dma_active_d;
  logic [15:0]    dma_addr_q, dma_addr_d;
  logic           dma_rw_n_q, dma_rw_n_d;
  logic [7:0]     dma_data_out_q, dma_data_out_d;

  logic           trigger;
  logic           last_byte;

  assign trigger   = !bus.CPU_RW_n && (bus.CPU_ADDR == DMA_REG_ADDR);
  assign last_byte = (index_q == LAST_INDEX);

  // Next-state, counter, page and data latch; parity free-runs (0 = get).
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    index_d  = index_q;
    latch_d  = latch_q;
    parity_d = ~parity_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          page_d  = bus.CPU_DATA_OUT;
          index_d = 8'h00;
          state_d = HALT;
        end
      end
      // The cycle after HALT has parity ~parity_q; it must be a get cycle.
      HALT:  state_d = parity_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        latch_d = bus.BUS_DATA_IN;
        state_d = WRITE;
      end
      WRITE: begin
        if (last_byte) begin
          state_d = IDLE;
        end else begin
          index_d = index_q + 8'h01;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track state.
  always_comb begin
    cpu_halt_d     = (state_d != IDLE);
    dma_active_d   = (state_d == READ) || (state_d == WRITE);
    dma_rw_n_d     = (state_d != WRITE);
    dma_addr_d     = 16'h0000;
    dma_data_out_d = 8'h00;
    if (state_d == READ) begin
      dma_addr_d = {page_d, index_d};
    end else if (state_d == WRITE) begin
      dma_addr_d     = OAMDATA_ADDR;
      dma_data_out_d = latch_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= IDLE;
      parity_q       <= 1'b0;
      page_q         <= 8'h00;
      index_q        <= 8'h00;
      latch_q        <= 8'h00;
      cpu_halt_q     <= 1'b0;
      dma_active_q   <= 1'b0;
      dma_addr_q     <= 16'h0000;
      dma_rw_n_q     <= 1'b1;
      dma_data_out_q <= 8'h00;
    end else begin
      state_q        <= state_d;
      parity_q       <= parity_d;
      page_q         <= page_d;
      index_q        <= index_d;
      latch_q        <= latch_d;
      cpu_halt_q     <= cpu_halt_d;
      dma_active_q   <= dma_active_d;
      dma_addr_q     <= dma_addr_d;
      dma_rw_n_q     <= dma_rw_n_d;
      dma_data_out_q <= dma_data_out_d;
    end
  end

  assign bus.CPU_HALT     = cpu_halt_q;
  assign bus.DMA_ACTIVE   = dma_active_q;
  assign bus.DMA_ADDR     = dma_addr_q;
  assign bus.DMA_RW_n     = dma_rw_n_q;
  assign bus.DMA_DATA_OUT = dma_data_out_q;

`ifdef OAM_DMA_DEBUG_EN
  logic done_q, done_d;

  // Done pulses in the first IDLE cycle after the final WRITE.
  always_comb begin
    done_d = (state_q == WRITE) && last_byte;
  end

  // Done pulse register.
  always_ff @(posedge CLK) begin
    if (RESET) done_q <= 1'b0;
    else       done_q <= done_d;
  end

  assign DMA_INDEX_debug = index_q;
  assign DMA_DONE_debug  = done_q;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: aligned/unaligned transfers, ignored retrigger,
// page $FF, reset mid-transfer and reset-vs-trigger priority.
module tb_oam_dma;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oam_dma_if bus ();

  // Memory model: read data = low address byte XOR key.
  logic [7:0] mem_key;
  assign bus.BUS_DATA_IN = bus.DMA_ADDR[7:0] ^ mem_key;

  // Expected get/put parity of the current cycle.
  logic tb_par;
  always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;

`ifdef OAM_DMA_DEBUG_EN
  logic [7:0] dbg_idx;
  logic       dbg_done;
  logic [7:0] idx_q[$];
  int         done_during;
  logic       post_done, post2_done;
`endif

  oam_dma dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
`ifdef OAM_DMA_DEBUG_EN
    ,
    .DMA_INDEX_debug(dbg_idx),
    .DMA_DONE_debug(dbg_done)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  int          halt_len, pre_len, bad_par, wr_addr_bad;
  logic        post_halt, post_active;
  logic [15:0] rd_q[$];
  logic [7:0]  obs_q[$];
  logic [7:0]  exp_q[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic trigger(input logic [7:0] page, input logic par);
    int n = 0;
    @(negedge clk);
    while (tb_par !== par && n < 4) begin
      @(negedge clk);
      n++;
    end
    bus.CPU_ADDR     = 16'h4014;
    bus.CPU_DATA_OUT = page;
    bus.CPU_RW_n     = 1'b0;
    @(posedge clk);
    #1;
    bus.CPU_ADDR     = 16'h0000;
    bus.CPU_DATA_OUT = 8'h00;
    bus.CPU_RW_n     = 1'b1;
  endtask

  // Records the bus trace of one transfer; no comparisons here.
  task automatic collect();
    int n = 0;
    halt_len = 0; pre_len = 0; bad_par = 0; wr_addr_bad = 0;
    rd_q.delete(); obs_q.delete();
`ifdef OAM_DMA_DEBUG_EN
    idx_q.delete(); done_during = 0;
`endif
    @(negedge clk);
    while (bus.CPU_HALT === 1'b1 && n < 600) begin
      halt_len++;
`ifdef OAM_DMA_DEBUG_EN
      if (dbg_done === 1'b1) done_during++;
`endif
      if (bus.DMA_ACTIVE !== 1'b1) pre_len++;
      else if (bus.DMA_RW_n === 1'b1) begin
        rd_q.push_back(bus.DMA_ADDR);
        if (tb_par !== 1'b0) bad_par++;
      end else begin
        if (bus.DMA_ADDR !== 16'h2004) wr_addr_bad++;
        obs_q.push_back(bus.DMA_DATA_OUT);
`ifdef OAM_DMA_DEBUG_EN
        idx_q.push_back(dbg_idx);
`endif
      end
      @(negedge clk);
      n++;
    end
    post_halt   = bus.CPU_HALT;
    post_active = bus.DMA_ACTIVE;
`ifdef OAM_DMA_DEBUG_EN
    post_done = dbg_done;
    @(negedge clk);
    post2_done = dbg_done;
`endif
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ mem_key);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; mem_key = 8'h00;
    bus.CPU_ADDR = 16'h0000; bus.CPU_DATA_OUT = 8'h00; bus.CPU_RW_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (bus.CPU_HALT !== 1'b0) $display("FAIL reset_halt got=%b exp=0", bus.CPU_HALT); else n_pass++;
    n_total++; if (bus.DMA_ACTIVE !== 1'b0) $display("FAIL reset_active got=%b exp=0", bus.DMA_ACTIVE); else n_pass++;
    n_total++; if (bus.DMA_ADDR !== 16'h0000) $display("FAIL reset_addr got=%h exp=0000", bus.DMA_ADDR); else n_pass++;
    n_total++; if (bus.DMA_RW_n !== 1'b1) $display("FAIL reset_rw_n got=%b exp=1", bus.DMA_RW_n); else n_pass++;
    n_total++; if (bus.DMA_DATA_OUT !== 8'h00) $display("FAIL reset_data got=%h exp=00", bus.DMA_DATA_OUT); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_aligned();
    int errs = 0;
    mem_key = 8'hA5;
    build_exp();
    trigger(8'h02, 1'b0);
    collect();
    n_total++; if (halt_len !== 513) $display("FAIL aligned_halt_len got=%0d exp=513", halt_len); else n_pass++;
    n_total++; if (pre_len !== 1) $display("FAIL aligned_pre_len got=%0d exp=1", pre_len); else n_pass++;
    n_total++; if (rd_q.size() !== 256) $display("FAIL aligned_reads got=%0d exp=256", rd_q.size()); else n_pass++;
    foreach (rd_q[i]) if (rd_q[i] !== {8'h02, 8'(i)}) errs++;
    n_total++; if (errs !== 0) $display("FAIL aligned_rd_addr bad=%0d exp=0 first=%h", errs, rd_q[0]); else n_pass++;
    n_total++; if (bad_par !== 0) $display("FAIL aligned_get_parity bad=%0d exp=0", bad_par); else n_pass++;
    n_total++; if (wr_addr_bad !== 0) $display("FAIL aligned_wr_addr bad=%0d exp=0", wr_addr_bad); else n_pass++;
    n_total++; if (obs_q.size() !== 256) $display("FAIL aligned_writes got=%0d exp=256", obs_q.size()); else n_pass++;
    errs = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) if (obs_q.pop_front() !== exp_q.pop_front()) errs++;
    n_total++; if (errs !== 0) $display("FAIL aligned_wr_data bad=%0d exp=0", errs); else n_pass++;
    n_total++; if (post_active !== 1'b0) $display("FAIL aligned_post_active got=%b exp=0", post_active); else n_pass++;
`ifdef OAM_DMA_DEBUG_EN
    errs = 0;
    foreach (idx_q[i]) if (idx_q[i] !== 8'(i)) errs++;
    n_total++; if (errs !== 0 || idx_q.size() !== 256) $display("FAIL dbg_index bad=%0d size=%0d exp=0/256", errs, idx_q.size()); else n_pass++;
    n_total++; if (done_during !== 0) $display("FAIL dbg_done_early got=%0d exp=0", done_during); else n_pass++;
    n_total++; if (post_done !== 1'b1) $display("FAIL dbg_done_pulse got=%b exp=1", post_done); else n_pass++;
    n_total++; if (post2_done !== 1'b0) $display("FAIL dbg_done_width got=%b exp=0", post2_done); else n_pass++;
`endif
  endtask

  task automatic test_align();
    mem_key = 8'h3C;
    trigger(8'h02, 1'b1);
    collect();
    n_total++; if (halt_len !== 514) $display("FAIL align_halt_len got=%0d exp=514", halt_len); else n_pass++;
    n_total++; if (pre_len !== 2) $display("FAIL align_pre_len got=%0d exp=2", pre_len); else n_pass++;
    n_total++; if (rd_q.size() < 1 || rd_q[0] !== 16'h0200) $display("FAIL align_first_read got=%h exp=0200", (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx); else n_pass++;
    n_total++; if (bad_par !== 0) $display("FAIL align_get_parity bad=%0d exp=0", bad_par); else n_pass++;
    n_total++; if (obs_q.size() < 256 || obs_q[255] !== 8'hC3) $display("FAIL align_last_data got=%h exp=c3", (obs_q.size() > 255) ? obs_q[255] : 8'hxx); else n_pass++;
  endtask

  task automatic test_retrigger_ignored();
    int errs = 0;
    mem_key = 8'h00;
    trigger(8'h03, 1'b0);
    fork
      collect();
      begin
        repeat (40) @(negedge clk);
        bus.CPU_ADDR = 16'h4014; bus.CPU_DATA_OUT = 8'h07; bus.CPU_RW_n = 1'b0;
        @(posedge clk);
        #1;
        bus.CPU_ADDR = 16'h0000; bus.CPU_DATA_OUT = 8'h00; bus.CPU_RW_n = 1'b1;
      end
    join
    foreach (rd_q[i]) if (rd_q[i] !== {8'h03, 8'(i)}) errs++;
    n_total++; if (errs !== 0 || rd_q.size() !== 256) $display("FAIL retrig_page bad=%0d size=%0d exp=0/256", errs, rd_q.size()); else n_pass++;
    n_total++; if (halt_len !== 513) $display("FAIL retrig_halt_len got=%0d exp=513", halt_len); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (bus.CPU_HALT !== 1'b0) $display("FAIL retrig_restart got=%b exp=0", bus.CPU_HALT); else n_pass++;
  endtask

  task automatic test_page_ff();
    mem_key = 8'h00;
    trigger(8'hFF, 1'b0);
    collect();
    n_total++; if (rd_q.size() !== 256 || rd_q[255] !== 16'hFFFF) $display("FAIL ff_last_read got=%h exp=ffff", (rd_q.size() > 255) ? rd_q[255] : 16'hxxxx); else n_pass++;
    n_total++; if (obs_q.size() !== 256 || obs_q[255] !== 8'hFF) $display("FAIL ff_last_data got=%h exp=ff", (obs_q.size() > 255) ? obs_q[255] : 8'hxx); else n_pass++;
    n_total++; if (post_halt !== 1'b0 || post_active !== 1'b0) $display("FAIL ff_idle got=%b%b exp=00", post_halt, post_active); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int writes = 0;
    int errs = 0;
    logic found = 1'b0;
    mem_key = 8'hA5;
    trigger(8'h04, 1'b0);
    for (int n = 0; n < 600 && !found; n++) begin
      @(negedge clk);
      if (bus.DMA_ACTIVE === 1'b1 && bus.DMA_RW_n === 1'b0) begin
        if (writes == 64) found = 1'b1;
        else writes++;
      end
    end
    n_total++; if (found !== 1'b1) $display("FAIL rstmid_reach got=%b exp=1", found); else n_pass++;
    n_total++; if (bus.DMA_DATA_OUT !== 8'hE5) $display("FAIL rstmid_data40 got=%h exp=e5", bus.DMA_DATA_OUT); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.CPU_HALT !== 1'b0) $display("FAIL rstmid_halt got=%b exp=0", bus.CPU_HALT); else n_pass++;
    n_total++; if (bus.DMA_ACTIVE !== 1'b0) $display("FAIL rstmid_active got=%b exp=0", bus.DMA_ACTIVE); else n_pass++;
    n_total++; if (bus.DMA_RW_n !== 1'b1) $display("FAIL rstmid_rw_n got=%b exp=1", bus.DMA_RW_n); else n_pass++;
    n_total++; if (bus.DMA_ADDR !== 16'h0000) $display("FAIL rstmid_addr got=%h exp=0000", bus.DMA_ADDR); else n_pass++;
    trigger(8'h05, 1'b0);
    collect();
    n_total++; if (rd_q.size() < 1 || rd_q[0] !== 16'h0500) $display("FAIL rstmid_restart_addr got=%h exp=0500", (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx); else n_pass++;
    n_total++; if (halt_len !== 513) $display("FAIL rstmid_halt_len got=%0d exp=513", halt_len); else n_pass++;
    build_exp();
    while (obs_q.size() > 0 && exp_q.size() > 0) if (obs_q.pop_front() !== exp_q.pop_front()) errs++;
    n_total++; if (errs !== 0) $display("FAIL rstmid_restart_data bad=%0d exp=0", errs); else n_pass++;
  endtask

  task automatic test_reset_wins();
    @(negedge clk);
    rst = 1'b1;
    bus.CPU_ADDR = 16'h4014; bus.CPU_DATA_OUT = 8'h06; bus.CPU_RW_n = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.CPU_ADDR = 16'h0000; bus.CPU_DATA_OUT = 8'h00; bus.CPU_RW_n = 1'b1;
    @(negedge clk);
    n_total++; if (bus.CPU_HALT !== 1'b0) $display("FAIL rstwin_halt got=%b exp=0", bus.CPU_HALT); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (bus.CPU_HALT !== 1'b0 || bus.DMA_ACTIVE !== 1'b0) $display("FAIL rstwin_idle got=%b%b exp=00", bus.CPU_HALT, bus.DMA_ACTIVE); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_align();
    test_retrigger_ignored();
    test_page_ff();
    test_reset_mid();
    test_reset_wins();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite OAM DMA engine for the CPU bus, mapped at $4014.
- A CPU write of page value P to $4014 halts the CPU and copies CPU addresses $PP00-$PPFF into the PPU's OAMDATA register ($2004), one byte per read/write cycle pair.
- While active, it drives the CPU-bus address, direction and data, ahead of the CPU-bus select logic and the PPU register port.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAMDATA_ADDR, 16'h2004, PPU OAMDATA write target.
- NUM_BYTES, 256, bytes per transfer; must be a power of two, at most 256.

Ports:
- CLK  input  1  CPU clock (CPU_CLK domain).
- RESET  input  1  synchronous, active-high reset.
- CPU_ADDR  input  16  CPU core address.
- CPU_DATA_OUT  input  8  CPU core write data.
- CPU_RW_n  input  1  CPU direction; 1 = read, 0 = write.
- BUS_DATA_IN  input  8  CPU data bus read value, valid in the same cycle as the address.
- CPU_HALT  output  1  stalls the CPU core; high while a transfer is pending or active.
- DMA_ACTIVE  output  1  bus muxed to DMA_ADDR/DMA_RW_n/DMA_DATA_OUT when high.
- DMA_ADDR  output  16  DMA bus address.
- DMA_RW_n  output  1  DMA bus direction.
- DMA_DATA_OUT  output  8  DMA write data.

Behaviour:
- Reset values:
  - CPU_HALT=0, DMA_ACTIVE=0, DMA_ADDR=16'h0000, DMA_RW_n=1, DMA_DATA_OUT=8'h00.
  - state=IDLE, page=0, index=0, parity=0.
- parity register:
  - Toggles every CLK; 0 = get cycle, 1 = put cycle.
  - Free-running in all states; cleared only by RESET.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - Trigger: CPU_RW_n=0 and CPU_ADDR==DMA_REG_ADDR.
  - On the trigger edge: latch page<=CPU_DATA_OUT, index<=0, go to HALT. CPU_HALT rises the cycle after the trigger.
- HALT:
  - One cycle; CPU_HALT=1, DMA_ACTIVE=0.
  - Next state is READ if the next cycle is a get cycle, else ALIGN.
- ALIGN: one cycle with CPU_HALT=1, DMA_ACTIVE=0; go to READ.
- READ:
  - DMA_ACTIVE=1, DMA_ADDR={page,index}, DMA_RW_n=1.
  - Capture BUS_DATA_IN into the data latch at the end of the cycle; go to WRITE.
- WRITE:
  - DMA_ACTIVE=1, DMA_ADDR=OAMDATA_ADDR, DMA_RW_n=0, DMA_DATA_OUT=latch.
  - If index==NUM_BYTES-1, go to IDLE. Otherwise index<=index+1 (8-bit, no wrap into page) and go to READ.
- Outputs are registered and derived from state.
- Total halt length:
  - 2*NUM_BYTES+1 cycles when aligned.
  - 2*NUM_BYTES+2 cycles with ALIGN (513/514 for 256).
  - CPU_HALT deasserts in the cycle after the final WRITE.
- Boundary cases:
  - Trigger while not IDLE: ignored; page is not reloaded.
  - Page $FF: addresses $FF00-$FFFF, no carry beyond 16 bits.
  - Page $20-$3F: reads PPU registers as a normal bus read; no special case.
  - RESET mid-transfer: next cycle is IDLE with all outputs at reset values; partial OAM contents are not rolled back.
  - Trigger on the same cycle as RESET: RESET wins.

Optional Feature:
- Macro: OAM_DMA_DEBUG_EN.
- Defined:
  - Adds output DMA_INDEX_debug[7:0], the current index.
  - Adds output DMA_DONE_debug, a one-cycle pulse in the cycle CPU_HALT falls.
- Undefined: neither port exists and no extra logic is built. Core behaviour is identical in both cases.

Decomposition:
- Shared package nes_bus_pkg holds:
  - the state enum oam_dma_state_t;
  - localparams for DMA_REG_ADDR and OAMDATA_ADDR (also used by the CPU-bus select logic).
- No sub-module: one FSM, one 8-bit counter and one data latch in a single module.

Test Plan:
- Parity 0 at trigger: write $02 to $4014 -> reads $0200..$02FF interleaved with 256 writes to $2004 carrying the same bytes; CPU_HALT high exactly 513 cycles.
- Trigger so that HALT falls on a get cycle -> one ALIGN cycle inserted; CPU_HALT high 514 cycles; first READ address $0200 on a get cycle.
- Write $07 to $4014 during an active transfer from page $03 -> ignored; transfer completes on $03xx; no restart.
- Page $FF with memory model returning low address byte -> last READ at $FFFF; last WRITE data $FF; then IDLE.
- RESET asserted at index=$40 in WRITE -> next cycle CPU_HALT=0, DMA_ACTIVE=0, DMA_RW_n=1; a fresh trigger restarts at index 0.
- With OAM_DMA_DEBUG_EN -> DMA_INDEX_debug counts $00..$FF; DMA_DONE_debug pulses once for exactly one cycle at completion.
